// File: rtl/clef_blitter_if.sv
// Bus bundle for clef_blitter: draw request/status, sprite ROM port and framebuffer write port.
// Framebuffer handshake: a write completes on a rising clock edge where fb_we=1 and fb_ready=1;
// while fb_we=1 and fb_ready=0 the writer holds fb_we/fb_addr/fb_wdata stable until accepted.
interface clef_blitter_if;
    logic        start;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic        busy;
    logic        done;
    logic [13:0] rom_addr;
    logic        rom_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic        fb_wdata;
    logic        fb_ready;

    modport slave (
        input  start, x0, y0, rom_data, fb_ready,
        output busy, done, rom_addr, fb_we, fb_addr, fb_wdata
    );

    modport master (
        output start, x0, y0, rom_data, fb_ready,
        input  busy, done, rom_addr, fb_we, fb_addr, fb_wdata
    );
endinterface

// File: rtl/clef_blitter.sv
// Sprite blitter: streams a SPRITE_W x SPRITE_H 1-bit sprite from ROM into the framebuffer at (x0,y0).
// Optional macro TRANSPARENT_EN: only set pixels are written; zero pixels are skipped.
module clef_blitter #(
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 80,
    parameter int FB_W     = 640,
    parameter int FB_H     = 480,
    parameter int ROM_LAT  = 2
) (
    input  logic         clk,
    input  logic         reset,
    clef_blitter_if.slave bus,
    output logic [1:0]   fsm_state,
    output logic [11:0]  clip_count
);
    localparam int ROWW   = $clog2(SPRITE_H);
    localparam int COLW   = $clog2(SPRITE_W);
    localparam int FIFO_D = ROM_LAT + 1;
    localparam int PW     = $clog2(FIFO_D);
    localparam int CNTW   = $clog2(FIFO_D + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [9:0]      x0_q;
    logic [8:0]      y0_q;
    logic [ROWW-1:0] row;
    logic [COLW-1:0] col;
    logic [13:0]     rom_addr_q;
    logic [11:0]     clip_q;

    logic            issue, last_issue, accept;

    logic            tag_v   [ROM_LAT];
    logic [ROWW-1:0] tag_row [ROM_LAT];
    logic [COLW-1:0] tag_col [ROM_LAT];
    logic            tags_busy;

    logic            ret_v, ret_wr, ret_pix, clipped;
    logic [10:0]     xs;
    logic [9:0]      ys;
    logic [18:0]     ret_addr;

    logic [19:0]     fifo_mem [FIFO_D];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CNTW-1:0] fifo_cnt;
    logic            fifo_empty, out_free, push, pop;

    logic            fb_we_q, fb_wdata_q;
    logic [18:0]     fb_addr_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
    endfunction

    // Address issue pauses whenever the framebuffer stalls; in-flight returns land in the FIFO.
    assign accept     = (state == S_IDLE) && bus.start;
    assign issue      = (state == S_ISSUE) && bus.fb_ready;
    assign last_issue = issue && (row == ROWW'(SPRITE_H - 1)) && (col == COLW'(SPRITE_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_q       <= '0;
            y0_q       <= '0;
            row        <= '0;
            col        <= '0;
            rom_addr_q <= '0;
        end else if (accept) begin
            x0_q       <= bus.x0;
            y0_q       <= bus.y0;
            row        <= '0;
            col        <= '0;
            rom_addr_q <= '0;
        end else if (issue && !last_issue) begin
            rom_addr_q <= rom_addr_q + 14'd1;
            if (col == COLW'(SPRITE_W - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Each issued address carries its (row,col) alongside the ROM pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_row[i] <= '0;
                tag_col[i] <= '0;
            end
        end else begin
            tag_v[0]   <= issue;
            tag_row[0] <= row;
            tag_col[0] <= col;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_row[i] <= tag_row[i-1];
                tag_col[i] <= tag_col[i-1];
            end
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) tags_busy = tags_busy | tag_v[i];
    end

    always_comb begin
        ret_v    = tag_v[ROM_LAT-1];
        xs       = {1'b0, x0_q} + 11'(tag_col[ROM_LAT-1]);
        ys       = {1'b0, y0_q} + 10'(tag_row[ROM_LAT-1]);
        clipped  = (xs >= 11'(FB_W)) || (ys >= 10'(FB_H));
        ret_addr = 19'(ys) * 19'(FB_W) + 19'(xs);
`ifdef TRANSPARENT_EN
        ret_wr   = ret_v && !clipped && bus.rom_data;
        ret_pix  = 1'b1;
`else
        ret_wr   = ret_v && !clipped;
        ret_pix  = bus.rom_data;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               clip_q <= '0;
        else if (accept)         clip_q <= '0;
        else if (ret_v && clipped) clip_q <= clip_q + 12'd1;
    end

    // Output register refills from the FIFO head first so ordering survives a stall.
    assign fifo_empty = (fifo_cnt == '0);
    assign out_free   = !fb_we_q || bus.fb_ready;
    assign pop        = out_free && !fifo_empty;
    assign push       = ret_wr && !(out_free && fifo_empty);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {ret_addr, ret_pix};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CNTW'(push) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= 1'b0;
        end else if (out_free) begin
            if (!fifo_empty) begin
                fb_we_q                 <= 1'b1;
                {fb_addr_q, fb_wdata_q} <= fifo_mem[rd_ptr];
            end else if (ret_wr) begin
                fb_we_q    <= 1'b1;
                fb_addr_q  <= ret_addr;
                fb_wdata_q <= ret_pix;
            end else begin
                fb_we_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_ISSUE;
            S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (!tags_busy && fifo_empty && out_free) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy     = (state == S_ISSUE) || (state == S_DRAIN);
    assign bus.done     = (state == S_DONE);
    assign bus.rom_addr = rom_addr_q;
    assign bus.fb_we    = fb_we_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_wdata = fb_wdata_q;
    assign fsm_state    = state;
    assign clip_count   = clip_q;
endmodule

// File: tb/tb_clef_blitter.sv
// Directed bench for clef_blitter: ROM model, write monitor and per-scenario checking tasks.
module tb_clef_blitter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    clef_blitter_if bus();
    logic [1:0]  fsm_state;
    logic [11:0] clip_count;

    clef_blitter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fsm_state  (fsm_state),
        .clip_count (clip_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: two registered stages, mode 0 all ones, mode 1 checkerboard.
    int   rom_mode = 0;
    logic rom_p1 = 1'b0;
    logic rom_q  = 1'b0;
    function automatic logic rom_pix(input int mode, input int addr);
        if (mode == 0) return 1'b1;
        return (((addr / 40) + (addr % 40)) % 2) == 0;
    endfunction
    always @(posedge clk) begin
        rom_p1 <= rom_pix(rom_mode, int'(bus.rom_addr));
        rom_q  <= rom_p1;
    end
    assign bus.rom_data = rom_q;

    logic [19:0] got_q[$];
    int          got_cyc[$];
    int          done_cyc[$];
    logic [19:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.fb_we && bus.fb_ready) begin
            got_q.push_back({bus.fb_addr, bus.fb_wdata});
            got_cyc.push_back(cyc);
        end
        if (bus.done) done_cyc.push_back(cyc);
    end

    task automatic build_exp(input int x, input int y, input int mode);
        exp_q.delete();
        for (int r = 0; r < 80; r++)
            for (int c = 0; c < 40; c++) begin
                logic p;
                p = rom_pix(mode, r * 40 + c);
                if ((x + c) < 640 && (y + r) < 480) begin
`ifdef TRANSPARENT_EN
                    if (p) exp_q.push_back({19'((y + r) * 640 + x + c), 1'b1});
`else
                    exp_q.push_back({19'((y + r) * 640 + x + c), p});
`endif
                end
            end
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic start_draw(input int x, input int y, output int n);
        @(posedge clk); #1;
        n = cyc;
        bus.start = 1'b1;
        bus.x0 = 10'(x);
        bus.y0 = 9'(y);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cyc.size() == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.fb_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.fb_we !== 1'b0) begin n_bad++; $display("FAIL rst_fb_we: got %b want 0", bus.fb_we); end
        n_cmp++; if (bus.rom_addr !== 14'd0) begin n_bad++; $display("FAIL rst_rom_addr: got %0d want 0", bus.rom_addr); end
        n_cmp++; if (bus.fb_addr !== 19'd0) begin n_bad++; $display("FAIL rst_fb_addr: got %0d want 0", bus.fb_addr); end
        n_cmp++; if (bus.fb_wdata !== 1'b0) begin n_bad++; $display("FAIL rst_fb_wdata: got %b want 0", bus.fb_wdata); end
        n_cmp++; if (fsm_state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int n, bad;
        rom_mode = 0;
        build_exp(100, 50, 0);
        clear_mon();
        start_draw(100, 50, n);
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.rom_addr !== 14'd0) begin n_bad++; $display("FAIL basic_addr0: got %0d want 0", bus.rom_addr); end
        @(negedge clk);
        n_cmp++; if (bus.rom_addr !== 14'd1) begin n_bad++; $display("FAIL basic_addr1: got %0d want 1", bus.rom_addr); end
        wait_done(4000);
        n_cmp++; if (got_q.size() != 3200) begin n_bad++; $display("FAIL basic_count: got %0d want 3200", got_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0 || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_seq: %0d differing of %0d got, want 0 differing of %0d", bad, got_q.size(), exp_q.size()); end
        n_cmp++; if (got_q.size() == 0 || got_q[0][19:1] !== 19'd32100) begin n_bad++; $display("FAIL basic_first_addr: got %0d want 32100", got_q.size() ? got_q[0][19:1] : 19'd0); end
        n_cmp++; if (got_cyc.size() == 0 || got_cyc[0] != n + 4) begin n_bad++; $display("FAIL basic_first_cyc: got %0d want %0d", got_cyc.size() ? got_cyc[0] : -1, n + 4); end
        n_cmp++; if (got_q.size() == 0 || got_q[got_q.size()-1][19:1] !== 19'd82699) begin n_bad++; $display("FAIL basic_last_addr: got %0d want 82699", got_q.size() ? got_q[got_q.size()-1][19:1] : 19'd0); end
        n_cmp++; if (got_cyc.size() == 0 || got_cyc[got_cyc.size()-1] != n + 3203) begin n_bad++; $display("FAIL basic_last_cyc: got %0d want %0d", got_cyc.size() ? got_cyc[got_cyc.size()-1] : -1, n + 3203); end
        n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != n + 3204) begin n_bad++; $display("FAIL basic_done: %0d pulses, first at %0d, want 1 at %0d", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, n + 3204); end
        n_cmp++; if (clip_count !== 12'd0) begin n_bad++; $display("FAIL basic_clip: got %0d want 0", clip_count); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_clip(input string name, input int x, input int y, input int want_wr);
        int n, bad;
        rom_mode = 0;
        build_exp(x, y, 0);
        clear_mon();
        start_draw(x, y, n);
        wait_done(4000);
        n_cmp++; if (got_q.size() != want_wr) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", name, got_q.size(), want_wr); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0 || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL %s_seq: %0d differing of %0d got, want 0 differing of %0d", name, bad, got_q.size(), exp_q.size()); end
        n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != n + 3204) begin n_bad++; $display("FAIL %s_done: %0d pulses, first at %0d, want 1 at %0d", name, done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, n + 3204); end
        n_cmp++; if (clip_count !== 12'(3200 - want_wr)) begin n_bad++; $display("FAIL %s_clip: got %0d want %0d", name, clip_count, 3200 - want_wr); end
    endtask

    task automatic test_stall();
        int n, bad;
        rom_mode = 0;
        build_exp(100, 50, 0);
        clear_mon();
        start_draw(100, 50, n);
        while (cyc != n + 1000) begin @(posedge clk); #1; end
        bus.fb_ready = 1'b0;
        while (cyc != n + 1005) begin @(posedge clk); #1; end
        bus.fb_ready = 1'b1;
        wait_done(4000);
        n_cmp++; if (got_q.size() != 3200) begin n_bad++; $display("FAIL stall_count: got %0d want 3200", got_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0 || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL stall_seq: %0d differing of %0d got, want 0 differing of %0d", bad, got_q.size(), exp_q.size()); end
        n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != n + 3209) begin n_bad++; $display("FAIL stall_done: %0d pulses, first at %0d, want 1 at %0d", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, n + 3209); end
    endtask

    task automatic test_pattern();
        int n, bad, ones;
        rom_mode = 1;
        build_exp(0, 0, 1);
        clear_mon();
        start_draw(0, 0, n);
        wait_done(4000);
`ifdef TRANSPARENT_EN
        n_cmp++; if (got_q.size() != 1600) begin n_bad++; $display("FAIL pat_count: got %0d want 1600", got_q.size()); end
`else
        n_cmp++; if (got_q.size() != 3200) begin n_bad++; $display("FAIL pat_count: got %0d want 3200", got_q.size()); end
`endif
        bad = 0;
        ones = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i][0] === 1'b1) ones++;
        n_cmp++; if (bad != 0 || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL pat_seq: %0d differing of %0d got, want 0 differing of %0d", bad, got_q.size(), exp_q.size()); end
        n_cmp++; if (ones != 1600) begin n_bad++; $display("FAIL pat_ones: got %0d want 1600", ones); end
        n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != n + 3204) begin n_bad++; $display("FAIL pat_done: %0d pulses, want 1 at %0d", done_cyc.size(), n + 3204); end
        rom_mode = 0;
    endtask

    task automatic test_reset_mid();
        int n, late, bad;
        rom_mode = 0;
        clear_mon();
        start_draw(100, 50, n);
        while (cyc != n + 500) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.fb_we !== 1'b0) begin n_bad++; $display("FAIL rmid_fb_we: got %b want 0", bus.fb_we); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        late = 0;
        for (int i = 0; i < got_cyc.size(); i++) if (got_cyc[i] >= n + 500) late++;
        n_cmp++; if (late != 0) begin n_bad++; $display("FAIL rmid_late_writes: got %0d want 0", late); end
        n_cmp++; if (got_q.size() != 496) begin n_bad++; $display("FAIL rmid_pre_writes: got %0d want 496", got_q.size()); end
        n_cmp++; if (done_cyc.size() != 0) begin n_bad++; $display("FAIL rmid_done: got %0d pulses want 0", done_cyc.size()); end
        build_exp(100, 50, 0);
        clear_mon();
        start_draw(100, 50, n);
        wait_done(4000);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0 || got_q.size() != 3200) begin n_bad++; $display("FAIL rmid_redraw: %0d differing of %0d got, want 0 of 3200", bad, got_q.size()); end
        n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != n + 3204) begin n_bad++; $display("FAIL rmid_redone: %0d pulses, want 1 at %0d", done_cyc.size(), n + 3204); end
    endtask

    task automatic test_busy_start();
        int n, bad;
        rom_mode = 0;
        build_exp(100, 50, 0);
        clear_mon();
        start_draw(100, 50, n);
        while (cyc != n + 10) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.x0 = 10'd300; bus.y0 = 9'd200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(4000);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0 || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL busy_start_seq: %0d differing of %0d got, want 0 of %0d", bad, got_q.size(), exp_q.size()); end
        n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != n + 3204) begin n_bad++; $display("FAIL busy_start_done: %0d pulses, want 1 at %0d", done_cyc.size(), n + 3204); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_clip("clip_x", 620, 0, 1600);
        test_clip("clip_y", 0, 440, 1600);
        test_clip("clip_all", 700, 0, 0);
        test_stall();
        test_pattern();
        test_reset_mid();
        test_busy_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clef_blitter.md
CLEF_BLITTER -- requirements
Module: clef_blitter

Interface
REQ-001 SPRITE_W, 40, sprite width in pixels.
REQ-002 SPRITE_H, 80, sprite height in pixels.
REQ-003 FB_W, 640, framebuffer width in pixels.
REQ-004 FB_H, 480, framebuffer height in pixels.
REQ-005 ROM_LAT, 2, cycles from rom_addr to valid rom_data.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to draw the sprite at (x0,y0).
REQ-009 x0  input  10  sprite left column; sampled only on an accepted start.
REQ-010 y0  input  9  sprite top row; sampled only on an accepted start.
REQ-011 busy  output  1  high while a draw is in progress.
REQ-012 done  output  1  one-cycle pulse when a draw completes.
REQ-013 rom_addr  output  14  sprite ROM address, row*SPRITE_W+col.
REQ-014 rom_data  input  1  sprite ROM pixel, valid ROM_LAT cycles after rom_addr.
REQ-015 fb_we  output  1  framebuffer write strobe.
REQ-016 fb_addr  output  19  framebuffer address, (y0+row)*FB_W+(x0+col).
REQ-017 fb_wdata  output  1  framebuffer pixel value.
REQ-018 fb_ready  input  1  framebuffer accepts a write in this cycle when high.

Function
REQ-019 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-020 IDLE->ISSUE on start; x0/y0 latched; row and col cleared; busy rises the next cycle.
REQ-021 start while busy is ignored, with no effect on state or latched coordinates.
REQ-022 ISSUE: one rom_addr per cycle, col fastest, row-major, 0 to SPRITE_W*SPRITE_H-1.
REQ-023 ISSUE->DRAIN after address 3199 issues; DRAIN->DONE once all in-flight pixels are written.
REQ-024 DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-025 Each returned pixel is tagged with its (row,col) through a ROM_LAT-deep tag pipeline.
REQ-026 fb_we, fb_addr and fb_wdata are registered, so a pixel appears on them ROM_LAT+1 cycles after its rom_addr.
REQ-027 Without stalls, start is sampled at cycle N, the first fb_we is at N+4, the last fb_we is at N+3203, and done is at N+3204.
REQ-028 A write completes in any cycle with fb_we=1 and fb_ready=1.
REQ-029 While fb_ready=0: fb_we, fb_addr and fb_wdata hold their values; rom_addr advance stops.
REQ-030 In-flight ROM returns during a stall go to a skid FIFO of depth ROM_LAT+1, with no loss, duplication or reordering.
REQ-031 Pixels with x0+col>=FB_W or y0+row>=FB_H are clipped: counted, never written.
REQ-032 A fully clipped draw still runs its full sequence and pulses done.
REQ-033 fb_addr arithmetic is 19-bit unsigned; x0+col and y0+row are computed at 11 and 10 bits before the clip compare.

Reset
REQ-034 Reset forces IDLE with busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_wdata=0, and the FIFO and counters empty.
REQ-035 Reset mid-draw aborts the draw immediately: no further fb_we and no done pulse.
REQ-036 A start accepted after reset deasserts runs a normal draw.

Configuration
REQ-037 When TRANSPARENT_EN is defined, only pixels with rom_data=1 are written (fb_wdata=1) and zero pixels are skipped, so they consume no fb_ready cycles.
REQ-038 When TRANSPARENT_EN is undefined, every unclipped pixel is written with fb_wdata=rom_data.

Verification
REQ-039 All-ones ROM, fb_ready=1, start at N with x0=100, y0=50 -> 3200 writes; first fb_addr=32100 at N+4; last fb_addr=(129*640)+139=82699; done at N+3204.
REQ-040 x0=620, y0=0 -> only cols 0..19 written, 1600 writes; done still pulses.
REQ-041 fb_ready low for 5 cycles starting at N+1000 -> write sequence identical to the unstalled run; done at N+3209.
REQ-042 Checkerboard ROM with TRANSPARENT_EN defined -> exactly 1600 writes, all with fb_wdata=1, only at 1-pixel addresses.
REQ-043 reset pulsed at N+500 -> fb_we=0 and busy=0 immediately with no done pulse; a new start draws all 3200 pixels.
REQ-044 Second start at N+10 with a different x0 -> ignored; all writes use the first coordinates; exactly one done pulse.
